uart_rx_deser_param: RTL and testbench
======================================

Name: uart_rx_deser_param

Overview:
Parametrised successor to the UART RX deserializer. Assembles a serial frame of runtime-selectable length (1..DATA_WIDTH bits) in LSB-first or MSB-first order, then optionally captures and checks a parity bit. Presents the completed word on a held output register with a one-cycle valid pulse. Sits between the RX bit sampler (Sampled_bit, sample strobe) and the RX FSM / stop-check logic.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame and width of Parallel_data (legal 1..32)
LEN_W, $clog2(DATA_WIDTH+1), width of Data_len and Bit_cnt (derived; not overridden)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  asynchronous active-low reset
Deser_clr  input  1  sync abort/start-of-frame clear; priority over Deser_en
Deser_en  input  1  sample strobe: Sampled_bit valid this cycle
Sampled_bit  input  1  serial bit from sampler
Data_len  input  LEN_W  data bits per frame; 0 or >DATA_WIDTH => DATA_WIDTH
Msb_first  input  1  0: first bit -> bit 0; 1: first bit -> bit Data_len-1
Par_en  input  1  1: one parity bit follows the data bits
Par_type  input  1  0 even, 1 odd
Parallel_data  output  DATA_WIDTH  last completed word, held until next completion
Data_valid  output  1  one-cycle pulse: Parallel_data/Par_err updated
Par_err  output  1  parity mismatch of last completed frame (0 if Par_en was 0)
Bit_cnt  output  LEN_W  data bits captured in current frame
Busy  output  1  high in COLLECT or PARITY

Behaviour:
- Async reset (Rst=0): state IDLE; shift register, Parallel_data, Bit_cnt = 0; Data_valid, Par_err, Busy = 0. Mid-frame reset discards the frame, no Data_valid.
- States: IDLE, COLLECT, PARITY.
- IDLE: Deser_en=1 -> capture first bit, latch Data_len (clamped), Msb_first, Par_en, Par_type into frame config; Bit_cnt=1; -> COLLECT (or complete immediately if clamped length=1, see below).
- Config is frozen for the frame; input changes mid-frame have no effect until next IDLE.
- COLLECT: each Deser_en captures one bit and increments Bit_cnt. Cycles without Deser_en hold all state.
- Bit placement: LSB-first: k-th bit (k=0..) -> position k. MSB-first: k-th bit -> position len-1-k. Positions >= len are 0 in the completed word.
- Capture of bit len (Bit_cnt reaching len): if frame Par_en=0 -> completion on that edge, -> IDLE; else -> PARITY.
- PARITY: next Deser_en captures parity bit; expected = XOR(data bits) XOR Par_type; Par_err = (bit != expected); completion on that edge, -> IDLE.
- Completion edge: Parallel_data <= assembled word, Par_err updated, Data_valid=1 for exactly the following cycle; shift register, Bit_cnt cleared to 0.
- Latency: Data_valid asserted the cycle after the Deser_en carrying the last data bit (Par_en=0) or the parity bit (Par_en=1).
- Deser_clr=1 (any state): -> IDLE, shift register and Bit_cnt = 0, Deser_en same cycle ignored; Parallel_data and Par_err unchanged; no Data_valid. A Data_valid pulse already due is not suppressed.
- Back-to-back: Deser_en in the cycle immediately after completion starts a new frame (IDLE accepts it).
- Busy = (state != IDLE).
- Bit_cnt saturates at len; never wraps.

Test Plan:
- Reset: Rst low mid-frame after 3 bits -> all outputs 0, state IDLE; next 8 strobes of 0xA5 LSB-first produce Parallel_data=0xA5, one Data_valid.
- LSB-first 8-bit, Par_en=0: bits 1,0,1,0,0,1,0,1 with gaps of 15 idle cycles -> Parallel_data=0xA5, Data_valid 1 cycle after 8th strobe, Par_err=0.
- MSB-first, Data_len=5: bits 1,0,1,1,0 -> Parallel_data=0x16, upper bits 0; Data_len changed to 8 mid-frame has no effect.
- Parity: Data_len=7, even, data 0x41 then parity 0 -> Par_err=0; repeat with parity 1 -> Par_err=1; odd with parity 1 on 0x41 -> Par_err=0.
- Deser_clr after 4 bits with simultaneous Deser_en -> Bit_cnt=0, Busy=0, Parallel_data holds previous 0xA5, no Data_valid; following full frame 0x3C completes normally.
- Data_len=0 and Data_len=12 -> treated as 8; back-to-back frames 0xFF then 0x00 with strobes on consecutive cycles -> two Data_valid pulses 8 cycles apart, correct words.

Source files
------------

// File: rtl/uart_rx_deser_param_if.sv
// Bus between the RX bit sampler / RX FSM and the parametrised deserializer.
// The sampler side (master) drives strobe, bit and frame config; the deserializer (slave) returns the word.
interface uart_rx_deser_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
);
  // Handshake: Deser_en qualifies Sampled_bit in the same cycle and there is no backpressure;
  // Data_valid is a one-cycle pulse with no ready, Parallel_data/Par_err hold until the next pulse.
  logic                  Deser_clr;
  logic                  Deser_en;
  logic                  Sampled_bit;
  logic [LEN_W-1:0]      Data_len;
  logic                  Msb_first;
  logic                  Par_en;
  logic                  Par_type;
  logic [DATA_WIDTH-1:0] Parallel_data;
  logic                  Data_valid;
  logic                  Par_err;
  logic [LEN_W-1:0]      Bit_cnt;
  logic                  Busy;
  logic [1:0]            Dbg_state;

  modport master (
    output Deser_clr, Deser_en, Sampled_bit, Data_len, Msb_first, Par_en, Par_type,
    input  Parallel_data, Data_valid, Par_err, Bit_cnt, Busy, Dbg_state
  );

  modport slave (
    input  Deser_clr, Deser_en, Sampled_bit, Data_len, Msb_first, Par_en, Par_type,
    output Parallel_data, Data_valid, Par_err, Bit_cnt, Busy, Dbg_state
  );
endinterface

// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: runtime frame length, LSB/MSB-first placement, optional parity check.
// Completed word is held on Parallel_data with a one-cycle Data_valid pulse.
module uart_rx_deser_param #(
  parameter  int DATA_WIDTH = 8,
  localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input logic                   Clk,
  input logic                   Rst,
  uart_rx_deser_param_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic [LEN_W-1:0]      r_cnt;
  logic [LEN_W-1:0]      r_len;
  logic                  r_msb;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_valid;
  logic                  r_par_err;

  logic                  w_idle;
  logic [LEN_W-1:0]      w_len_in;
  logic [LEN_W-1:0]      w_len;
  logic                  w_msb;
  logic                  w_par_en;
  logic [LEN_W-1:0]      w_cnt_inc;
  logic [LEN_W-1:0]      w_pos;
  logic                  w_last;
  logic                  w_par_exp;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // In IDLE the first bit is placed using the live config, which is latched on the same edge.
  assign w_idle    = (r_state == S_IDLE);
  assign w_len_in  = (bus.Data_len == '0 || bus.Data_len > LEN_W'(DATA_WIDTH))
                     ? LEN_W'(DATA_WIDTH) : bus.Data_len;
  assign w_len     = w_idle ? w_len_in      : r_len;
  assign w_msb     = w_idle ? bus.Msb_first : r_msb;
  assign w_par_en  = w_idle ? bus.Par_en    : r_par_en;
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_pos     = w_msb ? (w_len - w_cnt_inc) : r_cnt;
  assign w_last    = (w_cnt_inc == w_len);
  assign w_par_exp = (^r_shift) ^ r_par_type;

  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) == w_pos) w_shift_nxt[i] = bus.Sampled_bit;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_msb      <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.Deser_clr) begin
        r_state <= S_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (bus.Deser_en) begin
        case (r_state)
          S_IDLE, S_COLLECT: begin
            if (w_idle) begin
              r_len      <= w_len_in;
              r_msb      <= bus.Msb_first;
              r_par_en   <= bus.Par_en;
              r_par_type <= bus.Par_type;
            end
            if (w_last && !w_par_en) begin
              r_data    <= w_shift_nxt;
              r_par_err <= 1'b0;
              r_valid   <= 1'b1;
              r_shift   <= '0;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_shift <= w_shift_nxt;
              r_cnt   <= w_cnt_inc;
              r_state <= w_last ? S_PARITY : S_COLLECT;
            end
          end
          S_PARITY: begin
            r_data    <= r_shift;
            r_par_err <= (bus.Sampled_bit != w_par_exp);
            r_valid   <= 1'b1;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.Parallel_data = r_data;
  assign bus.Data_valid    = r_valid;
  assign bus.Par_err       = r_par_err;
  assign bus.Bit_cnt       = r_cnt;
  assign bus.Busy          = (r_state != S_IDLE);
  assign bus.Dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Bench for uart_rx_deser_param: directed frames plus random frames against a word-level model.
module tb_uart_rx_deser_param;

  localparam int DW = 8;

  logic Clk;
  logic Rst;

  uart_rx_deser_param_if #(.DATA_WIDTH(DW)) ifc ();

  uart_rx_deser_param #(.DATA_WIDTH(DW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          par_q[$];
  int            valid_cyc[$];
  logic [31:0]   last_word = '0;
  logic [DW-1:0] mon_w;
  logic          mon_p;

  always @(negedge Clk) begin
    if (Rst && ifc.Data_valid) begin
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_w = exp_q.pop_front();
        mon_p = par_q.pop_front();
        check("data", 32'(ifc.Parallel_data), 32'(mon_w));
        check("par_err", 32'(ifc.Par_err), 32'(mon_p));
        last_word = 32'(mon_w);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    ifc.Deser_en    = 1'b1;
    ifc.Sampled_bit = b;
    @(posedge Clk);
    #1;
    ifc.Deser_en    = 1'b0;
    ifc.Sampled_bit = $urandom_range(0, 1);
  endtask

  task automatic set_cfg(input int len_in, input logic msb, input logic pe, input logic pt);
    ifc.Data_len  = 4'(len_in);
    ifc.Msb_first = msb;
    ifc.Par_en    = pe;
    ifc.Par_type  = pt;
  endtask

  function automatic int eff_len(input int len_in);
    return (len_in == 0 || len_in > DW) ? DW : len_in;
  endfunction

  // Model: the word's low L bits are sent in order; result is the word masked to L bits.
  // scramble: 0 none, 1 Data_len->8 mid-frame, 2 all config randomised mid-frame.
  task automatic send_frame(input logic [DW-1:0] word, input int len_in, input logic msb,
                            input logic pe, input logic pt, input logic pbit,
                            input int gap, input int scramble);
    int            L;
    logic [31:0]   expw;
    logic          b;
    L    = eff_len(len_in);
    expw = 32'(word) & ((32'd1 << L) - 32'd1);
    exp_q.push_back(DW'(expw));
    par_q.push_back(pe ? (pbit != (logic'($countones(expw) % 2) ^ pt)) : 1'b0);
    set_cfg(len_in, msb, pe, pt);
    for (int k = 0; k < L; k++) begin
      b = msb ? word[L-1-k] : word[k];
      strobe(b);
      if (k == 0 && scramble == 1) ifc.Data_len = 4'd8;
      if (k == 0 && scramble == 2)
        set_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if (!(k == L - 1 && !pe)) begin
        check("bit_cnt", 32'(ifc.Bit_cnt), 32'(k + 1));
        check("busy", 32'(ifc.Busy), 32'd1);
        if (k != L - 1) idle(gap);
      end
    end
    if (pe) begin
      idle(gap);
      strobe(pbit);
    end
    check("valid_latency", 32'(ifc.Data_valid), 32'd1);
    check("cnt_clear", 32'(ifc.Bit_cnt), 32'd0);
    check("busy_done", 32'(ifc.Busy), 32'd0);
    if (gap > 0) begin
      idle(1);
      check("valid_pulse", 32'(ifc.Data_valid), 32'd0);
      idle(gap - 1);
    end
  endtask

  // Starts a frame, takes nbits (< len) bits, then aborts with clear plus a simultaneous strobe.
  task automatic abort_frame(input int len_in, input int nbits);
    set_cfg(len_in, $urandom_range(0, 1), 1'b0, 1'b0);
    for (int k = 0; k < nbits; k++) strobe($urandom_range(0, 1));
    check("abort_cnt_pre", 32'(ifc.Bit_cnt), 32'(nbits));
    ifc.Deser_clr = 1'b1;
    strobe(1'b1);
    ifc.Deser_clr = 1'b0;
    check("abort_cnt", 32'(ifc.Bit_cnt), 32'd0);
    check("abort_busy", 32'(ifc.Busy), 32'd0);
    check("abort_valid", 32'(ifc.Data_valid), 32'd0);
    check("abort_hold", 32'(ifc.Parallel_data), last_word);
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int L;
    Rst = 1'b0;
    ifc.Deser_clr = 1'b0;
    ifc.Deser_en = 1'b0;
    ifc.Sampled_bit = 1'b0;
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    check("rst_data", 32'(ifc.Parallel_data), 32'd0);
    check("rst_valid", 32'(ifc.Data_valid), 32'd0);
    check("rst_perr", 32'(ifc.Par_err), 32'd0);
    check("rst_cnt", 32'(ifc.Bit_cnt), 32'd0);
    check("rst_busy", 32'(ifc.Busy), 32'd0);
    Rst = 1'b1;
    idle(2);

    // Reset mid-frame after 3 bits of 0xA5
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    check("pre_rst_cnt", 32'(ifc.Bit_cnt), 32'd3);
    Rst = 1'b0;
    #1;
    check("midrst_cnt", 32'(ifc.Bit_cnt), 32'd0);
    check("midrst_busy", 32'(ifc.Busy), 32'd0);
    check("midrst_data", 32'(ifc.Parallel_data), 32'd0);
    check("midrst_valid", 32'(ifc.Data_valid), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    last_word = '0;
    idle(1);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(2);

    // LSB-first with wide gaps
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0);

    // Abort after 4 bits, then a normal frame
    abort_frame(8, 4);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    // MSB-first, 5 bits 1,0,1,1,0; upper word bits must not leak; length change mid-frame ignored
    send_frame(8'hF6, 5, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1);

    // Parity on 7-bit 0x41
    send_frame(8'h41, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    send_frame(8'h41, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
    send_frame(8'h41, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0);

    // Clamped lengths
    send_frame(8'hC3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    send_frame(8'h5A, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);

    // Back-to-back frames on consecutive strobes
    valid_cyc.delete();
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(3);
    check("b2b_count", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() == 2)
      check("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd8);

    // Random frames, including 1-bit frames and occasional aborts
    repeat (60) begin
      int len_in;
      len_in = $urandom_range(0, 15);
      L = eff_len(len_in);
      if ($urandom_range(0, 5) == 0 && L >= 2) begin
        abort_frame(len_in, $urandom_range(1, L - 1));
      end else begin
        send_frame(DW'($urandom), len_in, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 2));
      end
    end

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
